// File: rtl/branch_trace_sequencer.sv
// branch_trace_sequencer: buffers host branch records in a FIFO and replays them one at a time
// into a perceptron branch predictor, reporting each prediction and whether it was correct.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   push_valid/ready      host record handshake (ready = FIFO not full)
//   push_addr/taken       record address and resolved direction
//   pred_new_data         level to the predictor; it edge-detects the rise
//   pred_inst_addr        address of the record in flight (changes only on pop)
//   pred_dir_truth        ground-truth direction of the record in flight
//   pred_ready_in         predictor prediction-valid pulse
//   pred_prediction       predictor prediction bit
//   pred_training_done    predictor done pulse
//   result_valid          one-cycle pulse per completed record
//   result_pred/correct   captured prediction and prediction == truth
//   result_addr           address of the completed record
//   busy                  FSM active or FIFO not empty
//   timeout_err           sticky abort flag, cleared only by reset
//   stat_clr              synchronous statistics clear
//   stat_total/mispred    saturating completion / misprediction counters
//
// Build option: define BRANCH_TRACE_STATS_EN to build the statistics counters;
// otherwise they read 0 and stat_clr is ignored.
module branch_trace_sequencer #(
    parameter int ADDR_W         = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 63,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              push_taken,
    output logic              pred_new_data,
    output logic [ADDR_W-1:0] pred_inst_addr,
    output logic              pred_dir_truth,
    input  logic              pred_ready_in,
    input  logic              pred_prediction,
    input  logic              pred_training_done,
    output logic              result_valid,
    output logic              result_pred,
    output logic              result_correct,
    output logic [ADDR_W-1:0] result_addr,
    output logic              busy,
    output logic              timeout_err,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stat_total,
    output logic [CNT_W-1:0]  stat_mispred
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT_PRED, WAIT_DONE, GAP} state_t;

    logic [ADDR_W:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q, count_d;
    logic [ADDR_W:0] rd_rec;
    logic            full, empty, push_fire, pop;

    state_t            state_q, state_d;
    logic              new_data_q, new_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              truth_q, truth_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              cap_q, cap_d;
    logic              rv_q, rv_d;
    logic              rpred_q, rpred_d;
    logic              rcorr_q, rcorr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              terr_q, terr_d;
    logic              complete, fin_pred;

    assign full      = count_q == (PW+1)'(FIFO_DEPTH);
    assign empty     = count_q == '0;
    assign push_fire = push_valid && !full;
    // Pop decision uses the registered count, so a record pushed into an empty FIFO waits a cycle.
    assign pop       = state_q == IDLE && !empty;
    assign rd_rec    = mem_q[rd_ptr_q];
    assign count_d   = count_q + (PW+1)'(push_fire) - (PW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push_fire)
            mem_q[wr_ptr_q] <= {push_addr, push_taken};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_fire)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            new_data_q <= 1'b0;
            addr_q     <= '0;
            truth_q    <= 1'b0;
            timer_q    <= '0;
            cap_q      <= 1'b0;
            rv_q       <= 1'b0;
            rpred_q    <= 1'b0;
            rcorr_q    <= 1'b0;
            raddr_q    <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            new_data_q <= new_data_d;
            addr_q     <= addr_d;
            truth_q    <= truth_d;
            timer_q    <= timer_d;
            cap_q      <= cap_d;
            rv_q       <= rv_d;
            rpred_q    <= rpred_d;
            rcorr_q    <= rcorr_d;
            raddr_q    <= raddr_d;
            terr_q     <= terr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        new_data_d = new_data_q;
        addr_d     = addr_q;
        truth_d    = truth_q;
        timer_d    = timer_q;
        cap_d      = cap_q;
        rv_d       = 1'b0;
        rpred_d    = rpred_q;
        rcorr_d    = rcorr_q;
        raddr_d    = raddr_q;
        terr_d     = terr_q;
        complete   = 1'b0;
        fin_pred   = cap_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    addr_d     = rd_rec[ADDR_W:1];
                    truth_d    = rd_rec[0];
                    new_data_d = 1'b1;
                    timer_d    = '0;
                    state_d    = WAIT_PRED;
                end
            end
            WAIT_PRED, WAIT_DONE: begin
                timer_d = timer_q + TW'(1);
                if (state_q == WAIT_PRED && pred_ready_in) begin
                    cap_d    = pred_prediction;
                    fin_pred = pred_prediction;
                    complete = pred_training_done;
                    state_d  = WAIT_DONE;
                end else if (state_q == WAIT_DONE && pred_training_done) begin
                    complete = 1'b1;
                end
                // A response arriving on the timeout cycle still completes the record.
                if (complete) begin
                    rv_d       = 1'b1;
                    rpred_d    = fin_pred;
                    rcorr_d    = fin_pred == truth_q;
                    raddr_d    = addr_q;
                    new_data_d = 1'b0;
                    state_d    = GAP;
                end else if (timer_q == TW'(TIMEOUT_CYCLES)) begin
                    terr_d     = 1'b1;
                    new_data_d = 1'b0;
                    state_d    = GAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BRANCH_TRACE_STATS_EN
    logic [CNT_W-1:0] tot_q, tot_d, mis_q, mis_d;

    always_comb begin
        tot_d = tot_q;
        mis_d = mis_q;
        if (stat_clr) begin
            tot_d = '0;
            mis_d = '0;
        end else if (rv_d) begin
            if (~&tot_q)
                tot_d = tot_q + CNT_W'(1);
            if (!rcorr_d && ~&mis_q)
                mis_d = mis_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tot_q <= '0;
            mis_q <= '0;
        end else begin
            tot_q <= tot_d;
            mis_q <= mis_d;
        end
    end

    assign stat_total   = tot_q;
    assign stat_mispred = mis_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_total      = '0;
    assign stat_mispred    = '0;
`endif

    assign push_ready     = !full;
    assign pred_new_data  = new_data_q;
    assign pred_inst_addr = addr_q;
    assign pred_dir_truth = truth_q;
    assign result_valid   = rv_q;
    assign result_pred    = rpred_q;
    assign result_correct = rcorr_q;
    assign result_addr    = raddr_q;
    assign busy           = state_q != IDLE || !empty;
    assign timeout_err    = terr_q;

endmodule

// File: tb/tb_branch_trace_sequencer.sv
// tb_branch_trace_sequencer: directed self-checking bench for branch_trace_sequencer.
module tb_branch_trace_sequencer;
    localparam int AW = 8;
    localparam int CW = 2;
`ifdef BRANCH_TRACE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [AW-1:0] push_addr = '0;
    logic          push_taken = 1'b0;
    logic          pred_new_data;
    logic [AW-1:0] pred_inst_addr;
    logic          pred_dir_truth;
    logic          pred_ready_in = 1'b0;
    logic          pred_prediction = 1'b0;
    logic          pred_training_done = 1'b0;
    logic          result_valid;
    logic          result_pred;
    logic          result_correct;
    logic [AW-1:0] result_addr;
    logic          busy;
    logic          timeout_err;
    logic          stat_clr = 1'b0;
    logic [CW-1:0] stat_total;
    logic [CW-1:0] stat_mispred;

    int            checks = 0;
    int            errors = 0;
    int            rv_seen = 0;
    int            rv_exp = 0;
    int            len;
    logic [CW-1:0] exp_tot = '0;
    logic [CW-1:0] exp_mis = '0;

    branch_trace_sequencer #(
        .ADDR_W(AW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(63), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_addr(push_addr), .push_taken(push_taken),
        .pred_new_data(pred_new_data), .pred_inst_addr(pred_inst_addr),
        .pred_dir_truth(pred_dir_truth), .pred_ready_in(pred_ready_in),
        .pred_prediction(pred_prediction), .pred_training_done(pred_training_done),
        .result_valid(result_valid), .result_pred(result_pred),
        .result_correct(result_correct), .result_addr(result_addr),
        .busy(busy), .timeout_err(timeout_err), .stat_clr(stat_clr),
        .stat_total(stat_total), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && result_valid) rv_seen++;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic t);
        push_valid = 1'b1;
        push_addr  = a;
        push_taken = t;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic wait_nd();
        int n = 0;
        while (!pred_new_data && n < 200) begin
            tick();
            n++;
        end
        if (!pred_new_data) check("nd_rise_timeout", 32'(pred_new_data), 32'd1);
    endtask

    task automatic check_stats();
        check("stat_total", 32'(stat_total), 32'(STATS ? exp_tot : '0));
        check("stat_mispred", 32'(stat_mispred), 32'(STATS ? exp_mis : '0));
    endtask

    // Plays the predictor for one record: prediction after lat cycles, training_done gap
    // cycles after that (gap 0 = same cycle), optional stat_clr on the completing cycle.
    task automatic serve(input logic [AW-1:0] a, input logic t, input logic p,
                         input int lat, input int gap, input logic clr);
        logic ok;
        wait_nd();
        check("launch_addr", 32'(pred_inst_addr), 32'(a));
        check("launch_truth", 32'(pred_dir_truth), 32'(t));
        repeat (lat) tick();
        pred_prediction    = p;
        pred_ready_in      = 1'b1;
        pred_training_done = gap == 0;
        stat_clr           = clr && gap == 0;
        tick();
        pred_ready_in      = 1'b0;
        pred_training_done = 1'b0;
        pred_prediction    = 1'b0;
        stat_clr           = 1'b0;
        if (gap > 0) begin
            repeat (gap - 1) tick();
            check("hold_addr", 32'(pred_inst_addr), 32'(a));
            check("hold_truth", 32'(pred_dir_truth), 32'(t));
            check("hold_nd", 32'(pred_new_data), 32'd1);
            check("early_rv", 32'(result_valid), 32'd0);
            pred_training_done = 1'b1;
            stat_clr           = clr;
            tick();
            pred_training_done = 1'b0;
            stat_clr           = 1'b0;
        end
        rv_exp++;
        ok = p == t;
        if (clr) begin
            exp_tot = '0;
            exp_mis = '0;
        end else begin
            if (exp_tot != '1) exp_tot++;
            if (!ok && exp_mis != '1) exp_mis++;
        end
        check("result_valid", 32'(result_valid), 32'd1);
        check("result_addr", 32'(result_addr), 32'(a));
        check("result_pred", 32'(result_pred), 32'(p));
        check("result_correct", 32'(result_correct), 32'(ok));
        check("nd_fall", 32'(pred_new_data), 32'd0);
        check_stats();
        tick();
        check("rv_pulse", 32'(result_valid), 32'd0);
        check("gap_low", 32'(pred_new_data), 32'd0);
    endtask

    initial begin
        repeat (2) tick();
        check("rst_push_ready", 32'(push_ready), 32'd1);
        check("rst_nd", 32'(pred_new_data), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_addr", 32'(pred_inst_addr), 32'd0);
        check_stats();
        rst_n = 1'b1;
        tick();

        // Stray predictor pulses while idle are ignored.
        pred_ready_in = 1'b1; pred_training_done = 1'b1; pred_prediction = 1'b1;
        tick();
        pred_ready_in = 1'b0; pred_training_done = 1'b0; pred_prediction = 1'b0;
        tick();
        check("stray_idle_rv", 32'(result_valid), 32'd0);
        check("stray_idle_nd", 32'(pred_new_data), 32'd0);

        // Single record, no-training path; launch one edge after the push.
        push(8'h24, 1'b1);
        check("no_bypass", 32'(pred_new_data), 32'd0);
        check("busy_queued", 32'(busy), 32'd1);
        tick();
        check("launch_nd", 32'(pred_new_data), 32'd1);
        serve(8'h24, 1'b1, 1'b1, 4, 0, 1'b0);
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Training path with a stray done before the prediction.
        push(8'h10, 1'b0);
        wait_nd();
        tick();
        pred_training_done = 1'b1;
        tick();
        pred_training_done = 1'b0;
        check("stray_done_rv", 32'(result_valid), 32'd0);
        check("stray_done_nd", 32'(pred_new_data), 32'd1);
        serve(8'h10, 1'b0, 1'b1, 1, 12, 1'b0);

        // FIFO full behind a stalled record; refused push never appears.
        push(8'h41, 1'b0);
        wait_nd();
        push(8'h42, 1'b1);
        push(8'h43, 1'b0);
        push(8'h44, 1'b1);
        check("ready_before_last", 32'(push_ready), 32'd1);
        push(8'h45, 1'b0);
        check("full_ready", 32'(push_ready), 32'd0);
        push_valid = 1'b1; push_addr = 8'hEE; push_taken = 1'b1;
        tick();
        tick();
        push_valid = 1'b0;
        check("still_full", 32'(push_ready), 32'd0);
        serve(8'h41, 1'b0, 1'b0, 0, 0, 1'b0);
        serve(8'h42, 1'b1, 1'b0, 2, 3, 1'b0);
        serve(8'h43, 1'b0, 1'b1, 1, 0, 1'b0);
        serve(8'h44, 1'b1, 1'b0, 0, 0, 1'b0);
        serve(8'h45, 1'b0, 1'b1, 1, 2, 1'b1);
        repeat (4) tick();
        check("refused_never_launched", 32'(pred_new_data), 32'd0);
        check("drained_busy", 32'(busy), 32'd0);

        // Timeout: predictor silent; abort after the timer reaches 63.
        push(8'h5A, 1'b1);
        wait_nd();
        len = 0;
        while (pred_new_data && len < 200) begin
            len++;
            tick();
        end
        check("timeout_len", 32'(len), 32'd64);
        check("timeout_err", 32'(timeout_err), 32'd1);
        check("timeout_rv", 32'(result_valid), 32'd0);
        check("timeout_no_result", 32'(rv_seen), 32'(rv_exp));
        check_stats();
        push(8'h33, 1'b0);
        serve(8'h33, 1'b0, 1'b0, 3, 0, 1'b0);
        check("timeout_sticky", 32'(timeout_err), 32'd1);

        // Reset mid-operation drops new_data and discards queued records.
        push(8'h61, 1'b1);
        push(8'h62, 1'b0);
        check("pre_reset_nd", 32'(pred_new_data), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_nd", 32'(pred_new_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_terr", 32'(timeout_err), 32'd0);
        check("mid_rst_ready", 32'(push_ready), 32'd1);
        rst_n = 1'b1;
        exp_tot = '0;
        exp_mis = '0;
        repeat (5) tick();
        check("discarded_nd", 32'(pred_new_data), 32'd0);
        check_stats();
        check("rv_count", 32'(rv_seen), 32'(rv_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
